// File: rtl/uart_servo_array_if.sv
`timescale 1ns/1ps
// uart_servo_array_if: pin-level bundle of the servo controller.
// slave  = controller side (consumes rx_pin, drives servo/buzzer/status pins)
// master = board/host side (drives rx_pin, observes the rest)
interface uart_servo_array_if #(
   parameter int N_CH = 4
);
   logic            rx_pin;
   logic [N_CH-1:0] servo_pwm;
   logic            buzzer;
   logic            cmd_valid;
   logic            cmd_err;

   modport master (
      output rx_pin,
      input  servo_pwm,
      input  buzzer,
      input  cmd_valid,
      input  cmd_err
   );

   modport slave (
      input  rx_pin,
      output servo_pwm,
      output buzzer,
      output cmd_valid,
      output cmd_err
   );
endinterface

// File: rtl/uart_servo_array.sv
`timescale 1ns/1ps
// uart_servo_array: UART-commanded multi-channel hobby-servo PWM controller.
// A command byte {channel[7:4], position[3:0]} writes a pending position;
// pending positions are promoted to the PWM generators only at a frame wrap so
// pulses are never cut short or stretched. Any real position change fires
// the active-low buzzer for BEEP_MS (retriggerable).
// Optional feature: define UART_SERVO_PARITY_EN for 8E1 framing with parity
// check; otherwise the receiver is plain 8N1.
module uart_servo_array #(
   parameter int CLK_HZ    = 50000000,
   parameter int BAUD      = 9600,
   parameter int N_CH      = 4,
   parameter int PERIOD_US = 20000,
   parameter int MIN_US    = 1000,
   parameter int MAX_US    = 2000,
   parameter int BEEP_MS   = 1000
) (
   input logic            clk,
   input logic            rst,
   uart_servo_array_if.slave bus
);

   localparam int CYC_US    = CLK_HZ / 1000000;
   localparam int BIT_CYC   = CLK_HZ / BAUD;
   localparam int HALF_CYC  = BIT_CYC / 2;
   localparam int FRAME_CYC = PERIOD_US * CYC_US;
   localparam int BEEP_CYC  = BEEP_MS * (CLK_HZ / 1000);
   localparam int BW        = $clog2(BIT_CYC + 1);
   localparam int FW        = $clog2(FRAME_CYC + 1);
   localparam int EW        = $clog2(BEEP_CYC + 1);

   localparam logic [BW-1:0] BIT_LAST   = BW'(BIT_CYC - 1);
   localparam logic [BW-1:0] HALF_LAST  = BW'(HALF_CYC - 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYC - 1);
   localparam logic [EW-1:0] BEEP_LOAD  = EW'(BEEP_CYC);
   localparam logic [4:0]    N_CH_L     = 5'(N_CH);

`ifdef UART_SERVO_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} rx_state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_t;
`endif

   // receiver
   logic          rx_s1_q, rx_s2_q, rx_prev_q;
   rx_state_t     state_q, state_d;
   logic [BW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
`ifdef UART_SERVO_PARITY_EN
   logic          par_q, par_d;
`endif
   logic          byte_done;
   logic          byte_ok;

   // command decode
   logic [3:0]      cmd_ch;
   logic [3:0]      cmd_pos;
   logic            ch_ok;
   logic            accept;
   logic [N_CH-1:0] trig_vec;

   // frame, buzzer and status outputs
   logic [FW-1:0] frame_q, frame_d;
   logic          frame_wrap;
   logic [EW-1:0] beep_q, beep_d;
   logic          buzzer_q, buzzer_d;
   logic          cmd_valid_q, cmd_valid_d;
   logic          cmd_err_q, cmd_err_d;
   logic [FW-1:0] width_lut [16];

   // Pulse width per position, folded to constants at elaboration
   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_lut
         assign width_lut[gi] = FW'((MIN_US + (gi * (MAX_US - MIN_US)) / 15) * CYC_US);
      end
   endgenerate

   // Two-flop synchroniser on rx_pin plus one more stage for edge detect
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_s1_q   <= bus.rx_pin;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
      end
   end

   // Receiver state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
`ifdef UART_SERVO_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
`ifdef UART_SERVO_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   // Receiver next state: half-bit start qualification, then mid-bit samples
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + BW'(1);
      bit_d     = bit_q;
      shift_d   = shift_q;
`ifdef UART_SERVO_PARITY_EN
      par_d     = par_q;
`endif
      byte_done = 1'b0;
      byte_ok   = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (rx_prev_q && !rx_s2_q) begin
               state_d = S_START;
            end
         end
         S_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               bit_d = '0;
               // line back high at mid-start means a glitch, dropped silently
               state_d = rx_s2_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_s2_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef UART_SERVO_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_SERVO_PARITY_EN
         S_PARITY: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               par_d   = rx_s2_q;
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d     = '0;
               state_d   = S_IDLE;
               byte_done = 1'b1;
`ifdef UART_SERVO_PARITY_EN
               byte_ok   = rx_s2_q && !(^{shift_q, par_q});
`else
               byte_ok   = rx_s2_q;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign cmd_ch  = shift_q[7:4];
   assign cmd_pos = shift_q[3:0];
   assign ch_ok   = {1'b0, cmd_ch} < N_CH_L;
   assign accept  = byte_done && byte_ok && ch_ok;

   // Per-channel pending/active positions and PWM comparator
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_ch
         logic [3:0] pend_q, pend_d;
         logic [3:0] act_q, act_d;
         logic       pwm_q, pwm_d;
         logic       hit;

         // pending takes accepted commands; active follows pending only at wrap
         always_comb begin
            hit    = accept && (cmd_ch == 4'(gi));
            pend_d = hit ? cmd_pos : pend_q;
            act_d  = frame_wrap ? pend_q : act_q;
            pwm_d  = frame_q < width_lut[act_q];
         end

         // channel registers
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               pend_q <= '0;
               act_q  <= '0;
               pwm_q  <= 1'b0;
            end else begin
               pend_q <= pend_d;
               act_q  <= act_d;
               pwm_q  <= pwm_d;
            end
         end

         assign trig_vec[gi]      = hit && (pend_q != cmd_pos);
         assign bus.servo_pwm[gi] = pwm_q;
      end
   endgenerate

   assign frame_wrap = (frame_q == FRAME_LAST);

   // Frame counter, retriggerable beep timer and status pulses
   always_comb begin
      frame_d     = frame_wrap ? '0 : frame_q + FW'(1);
      beep_d      = beep_q;
      if (|trig_vec) begin
         beep_d = BEEP_LOAD;
      end else if (beep_q != '0) begin
         beep_d = beep_q - EW'(1);
      end
      buzzer_d    = (beep_q == '0);
      cmd_valid_d = accept;
      cmd_err_d   = byte_done && !(byte_ok && ch_ok);
   end

   // Shared registers for frame, buzzer and status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_q     <= '0;
         beep_q      <= '0;
         buzzer_q    <= 1'b1;
         cmd_valid_q <= 1'b0;
         cmd_err_q   <= 1'b0;
      end else begin
         frame_q     <= frame_d;
         beep_q      <= beep_d;
         buzzer_q    <= buzzer_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_err_q   <= cmd_err_d;
      end
   end

   assign bus.buzzer    = buzzer_q;
   assign bus.cmd_valid = cmd_valid_q;
   assign bus.cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_uart_servo_array.sv
`timescale 1ns/1ps
// tb_uart_servo_array: table-driven directed vectors, hand sequences for
// retrigger/glitch/async reset, and a randomized run against a small
// behavioural model of pending positions and beep timing.
module tb_uart_servo_array;

   localparam int CLK_HZ    = 1000000;
   localparam int BAUD      = 100000;
   localparam int N_CH      = 4;
   localparam int PERIOD_US = 2000;
   localparam int MIN_US    = 100;
   localparam int MAX_US    = 1500;
   localparam int BEEP_MS   = 1;
   localparam int BITC      = CLK_HZ / BAUD;
   localparam int BEEP_CYC  = BEEP_MS * CLK_HZ / 1000;
   localparam int FRAME_CYC = PERIOD_US * CLK_HZ / 1000000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   uart_servo_array_if #(.N_CH(N_CH)) bus ();

   uart_servo_array #(
      .CLK_HZ(CLK_HZ), .BAUD(BAUD), .N_CH(N_CH), .PERIOD_US(PERIOD_US),
      .MIN_US(MIN_US), .MAX_US(MAX_US), .BEEP_MS(BEEP_MS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

`ifdef UART_SERVO_PARITY_EN
   bit par_bad = 1'b0;
`endif

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // pulse/buzzer monitor
   int n_valid = 0, n_err = 0, last_cyc = 0, n_buz_rise = 0;
   int buz_after = 1;
   bit pulse_prev = 1'b0, buz_prev = 1'b1;
   always @(negedge clk) begin
      if (!rst) begin
         if (pulse_prev) buz_after = int'(bus.buzzer);
         if (bus.cmd_valid || bus.cmd_err)
            chk("valid_err_exclusive", int'(bus.cmd_valid && bus.cmd_err), 0);
         if (bus.cmd_valid) begin n_valid++; last_cyc = cyc; end
         if (bus.cmd_err)   begin n_err++;   last_cyc = cyc; end
         if (bus.buzzer && !buz_prev) n_buz_rise++;
         buz_prev   = bus.buzzer;
         pulse_prev = bus.cmd_valid || bus.cmd_err;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   function automatic int model_width(input int pos);
      return (MIN_US + (pos * (MAX_US - MIN_US)) / 15) * (CLK_HZ / 1000000);
   endfunction

   task automatic send_byte(input logic [7:0] b, input bit stop);
      @(negedge clk);
      bus.rx_pin = 1'b0;
      repeat (BITC) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         bus.rx_pin = b[k];
         repeat (BITC) @(negedge clk);
      end
`ifdef UART_SERVO_PARITY_EN
      bus.rx_pin = (^b) ^ par_bad;
      repeat (BITC) @(negedge clk);
`endif
      bus.rx_pin = stop;
      repeat (BITC) @(negedge clk);
      bus.rx_pin = 1'b1;
   endtask

   task automatic wait_buz_high(output int t);
      t = -1;
      for (int i = 0; i < 1500; i++) begin
         if (bus.buzzer) begin
            t = cyc;
            break;
         end
         @(negedge clk);
      end
   endtask

   // high time and rise-to-rise period of one channel, -1 on timeout
   task automatic meas_pwm(input int ch, output int hi, output int per);
      int t0;
      hi = -1;
      per = -1;
      for (int i = 0; i < 2100 && bus.servo_pwm[ch]; i++) @(negedge clk);
      for (int i = 0; i < 2100 && !bus.servo_pwm[ch]; i++) @(negedge clk);
      if (bus.servo_pwm[ch]) begin
         t0 = cyc;
         for (int i = 0; i < 2100 && bus.servo_pwm[ch]; i++) @(negedge clk);
         hi = cyc - t0;
         for (int i = 0; i < 2100 && !bus.servo_pwm[ch]; i++) @(negedge clk);
         per = cyc - t0;
      end
   endtask

   typedef struct {
      logic [7:0] data;
      bit         stop;
      int         exp_valid;
      int         exp_err;
      int         exp_beep;
      int         chk_ch;
      int         exp_w;
   } vec_t;

   vec_t tbl [5];
   int   pend_m [N_CH];

   initial begin
      int hi, per, t, v0, e0, len, c1, c2, r0, low_until;
      int ch, pos, exp_ok, trig, exp_buz;
      bit stop;

      tbl[0] = '{8'h2F, 1'b1, 1, 0, 1000, 2, 1500};
      tbl[1] = '{8'h17, 1'b1, 1, 0, 1000, 1, 753};
      tbl[2] = '{8'h17, 1'b1, 1, 0, 0,    1, 753};
      tbl[3] = '{8'h53, 1'b1, 0, 1, 0,    3, 100};
      tbl[4] = '{8'h21, 1'b0, 0, 1, 0,    2, 1500};
      for (int i = 0; i < N_CH; i++) pend_m[i] = 0;

      bus.rx_pin = 1'b1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_pwm", int'(bus.servo_pwm), 0);
      chk("reset_buzzer", int'(bus.buzzer), 1);
      chk("reset_valid", int'(bus.cmd_valid), 0);
      chk("reset_err", int'(bus.cmd_err), 0);
      rst = 1'b0;

      meas_pwm(0, hi, per);
      chk("init_width_ch0", hi, 100);
      chk("init_period_ch0", per, FRAME_CYC);
      $display("init ch0 width=%0d period=%0d", hi, per);

      // directed table
      for (int i = 0; i < 5; i++) begin
         wait_buz_high(t);
         v0 = n_valid;
         e0 = n_err;
         send_byte(tbl[i].data, tbl[i].stop);
         chk("tbl_valid", n_valid - v0, tbl[i].exp_valid);
         chk("tbl_err", n_err - e0, tbl[i].exp_err);
         len = 0;
         if (buz_after == 0) begin
            wait_buz_high(t);
            len = (t < 0) ? -1 : t - last_cyc - 1;
         end
         chk("tbl_beep_len", len, tbl[i].exp_beep);
         meas_pwm(tbl[i].chk_ch, hi, per);
         chk("tbl_width", hi, tbl[i].exp_w);
         $display("tx %02h stop=%0d valid=%0d err=%0d beep=%0d ch%0d width=%0d",
                  tbl[i].data, tbl[i].stop, n_valid - v0, n_err - e0, len, tbl[i].chk_ch, hi);
      end
      pend_m[2] = 15;
      pend_m[1] = 7;

      // retrigger: second change 500 cycles after first extends the beep
      wait_buz_high(t);
      r0 = n_buz_rise;
      send_byte(8'h01, 1'b1);
      c1 = last_cyc;
      for (int i = 0; i < 700 && cyc < c1 + 500; i++) @(negedge clk);
      send_byte(8'h02, 1'b1);
      c2 = last_cyc;
      wait_buz_high(t);
      @(negedge clk);
      chk("retrig_len", (t < 0) ? -1 : t - c2 - 1, BEEP_CYC);
      chk("retrig_rises", n_buz_rise - r0, 1);
      meas_pwm(0, hi, per);
      chk("retrig_width_ch0", hi, 286);
      pend_m[0] = 2;
      $display("retrigger gap=%0d beep_end=%0d ch0 width=%0d", c2 - c1, t - c2 - 1, hi);

      // 3-cycle glitch must be ignored
      v0 = n_valid;
      e0 = n_err;
      @(negedge clk);
      bus.rx_pin = 1'b0;
      repeat (3) @(negedge clk);
      bus.rx_pin = 1'b1;
      repeat (100) @(negedge clk);
      chk("glitch_valid", n_valid - v0, 0);
      chk("glitch_err", n_err - e0, 0);
      $display("glitch pulses=%0d", (n_valid - v0) + (n_err - e0));

      // randomized commands against the reference model
      low_until = 0;
      for (int n = 0; n < 24; n++) begin
         ch   = int'($urandom_range(0, 7));
         pos  = int'($urandom_range(0, 15));
         stop = ($urandom_range(0, 7) != 0);
         v0 = n_valid;
         e0 = n_err;
         send_byte(8'((ch << 4) | pos), stop);
         exp_ok = (stop && ch < N_CH) ? 1 : 0;
         trig   = (exp_ok == 1 && pend_m[ch % N_CH] != pos) ? 1 : 0;
         exp_buz = (trig == 1 || last_cyc + 1 <= low_until) ? 0 : 1;
         chk("rnd_valid", n_valid - v0, exp_ok);
         chk("rnd_err", n_err - e0, 1 - exp_ok);
         chk("rnd_buzzer", buz_after, exp_buz);
         if (trig == 1) low_until = last_cyc + BEEP_CYC;
         if (exp_ok == 1) pend_m[ch] = pos;
         $display("rnd tx %02h stop=%0d valid=%0d err=%0d buzzer=%0d",
                  8'((ch << 4) | pos), stop, n_valid - v0, n_err - e0, buz_after);
         repeat ($urandom_range(0, 20)) @(negedge clk);
      end
      for (int i = 0; i < N_CH; i++) begin
         meas_pwm(i, hi, per);
         chk("rnd_final_width", hi, model_width(pend_m[i]));
         $display("final ch%0d pos=%0d width=%0d", i, pend_m[i], hi);
      end

`ifdef UART_SERVO_PARITY_EN
      v0 = n_valid;
      e0 = n_err;
      par_bad = 1'b0;
      send_byte(8'h03, 1'b1);
      chk("parity_good_valid", n_valid - v0, 1);
      v0 = n_valid;
      e0 = n_err;
      par_bad = 1'b1;
      send_byte(8'h03, 1'b1);
      chk("parity_bad_err", n_err - e0, 1);
      chk("parity_bad_valid", n_valid - v0, 0);
      par_bad = 1'b0;
      pend_m[0] = 3;
      $display("parity tx 03 good then bad");
`endif

      // asynchronous reset in the middle of a beep
      send_byte(8'(8'h30 | ((pend_m[3] + 1) % 16)), 1'b1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_pwm", int'(bus.servo_pwm), 0);
      chk("async_rst_buzzer", int'(bus.buzzer), 1);
      chk("async_rst_valid", int'(bus.cmd_valid), 0);
      chk("async_rst_err", int'(bus.cmd_err), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("post_rst_buzzer", int'(bus.buzzer), 1);
      meas_pwm(2, hi, per);
      chk("post_rst_width_ch2", hi, 100);
      chk("post_rst_period_ch2", per, FRAME_CYC);
      meas_pwm(1, hi, per);
      chk("post_rst_width_ch1", hi, 100);
      $display("async reset ch1 width=%0d", hi);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_servo_array.md
# uart_servo_array

Multi-channel UART-commanded servo controller with position-change buzzer, the parametrised successor to the single-servo UART lock. It contains its own 8N1 UART receiver and a command decoder. It drives N_CH independent hobby-servo PWM outputs, each at one of 16 positions. The buzzer beeps whenever any channel's stored position actually changes. It sits between the board RX pin and the servo/buzzer header pins.

## Interface
- CLK_HZ, 50000000, system clock frequency; must be a multiple of 1000000.
- BAUD, 9600, UART bit rate; CLK_HZ/BAUD ≥ 8.
- N_CH, 4, number of servo channels, 1..16.
- PERIOD_US, 20000, PWM frame period in µs.
- MIN_US, 1000, pulse width at position 0.
- MAX_US, 2000, pulse width at position 15; must satisfy MIN_US < MAX_US < PERIOD_US.
- BEEP_MS, 1000, buzzer on-time per trigger.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active high.
- rx_pin  in  1  UART RX line, idle high, asynchronous to clk.
- servo_pwm  out  N_CH  per-channel PWM, active high.
- buzzer  out  1  active-low buzzer drive (0 = sounding).
- cmd_valid  out  1  one-cycle pulse per accepted command.
- cmd_err  out  1  one-cycle pulse per rejected byte.

## Operation
- Reset values: servo_pwm = 0, buzzer = 1, cmd_valid = 0, cmd_err = 0, all stored positions = 0, RX FSM = IDLE, frame counter = 0.
- rx_pin passes through a 2-FF synchroniser, preset to 1 on reset. All RX logic uses the synchronised signal.
- RX FSM states and transitions:
  - IDLE: go to START on a synchronised falling edge.
  - START: wait half a bit. If the line is 1, this is a glitch; return to IDLE with no error. If 0, go to DATA.
  - DATA: take 8 samples, one per bit time, at mid-bit, LSB first.
  - (PARITY): present only when the macro is defined; see Configuration.
  - STOP: sample once more at mid-bit. If the sample is 0, raise a framing error.
- Command byte format: bits [7:4] are the channel, bits [3:0] are the position.
- Rejected bytes produce a cmd_err pulse and leave the stored positions unchanged:
  - framing error;
  - channel ≥ N_CH.
- An accepted byte produces a cmd_valid pulse and writes the position into the channel's pending register.
- Pulse width in cycles: (MIN_US + (pos·(MAX_US−MIN_US))/15)·(CLK_HZ/1000000).
  - Integer division truncates.
  - The multiplier may be a synthesis-time lookup or a multiplier; output is bit-exact to this formula.
- PWM framing:
  - One shared frame counter counts 0 .. PERIOD_US·CLK_HZ/1000000 − 1, then wraps to 0.
  - servo_pwm[i] = 1 while the frame counter < width_i.
  - A pending position is latched into the active register only when the frame counter wraps to 0. Pulses are therefore never truncated or stretched mid-frame.
- Buzzer:
  - Trigger: a command is accepted whose position differs from that channel's current pending value.
  - A trigger loads the beep counter with BEEP_MS·CLK_HZ/1000 and drives buzzer = 0.
  - A trigger during an active beep reloads the counter (retrigger extends the beep).
  - A command with the same position pulses cmd_valid but does not trigger a beep.
- Reset asserted mid-frame or mid-beep returns every output to its reset value asynchronously. The byte being received at that moment is dropped.

## Timing
- cmd_valid and cmd_err fire in the cycle after the stop-bit sample, at about 9.5 bit times after the start edge plus the 2-cycle synchroniser delay.
- The pending register updates on the same edge as cmd_valid.
- buzzer falls one cycle after cmd_valid. It stays 0 for exactly BEEP_MS·CLK_HZ/1000 cycles after the last trigger, then returns to 1.
- New servo widths appear at the first frame wrap after cmd_valid. Worst-case latency is one PWM period.
- The RX FSM returns to IDLE in the cycle after the stop-bit sample. Back-to-back bytes with a single stop bit are received without loss.
- cmd_valid and cmd_err are never asserted together.

## Configuration
- UART_SERVO_PARITY_EN defined:
  - The frame is 8E1. A PARITY state samples one bit after DATA.
  - A byte is rejected with cmd_err if the data+parity XOR is 1.
  - Byte latency grows by one bit time.
- UART_SERVO_PARITY_EN undefined: the frame is 8N1 and the PARITY state does not exist.

## Test plan
All scenarios use CLK_HZ=1000000, BAUD=100000, PERIOD_US=2000, MIN_US=100, MAX_US=1500, BEEP_MS=1, N_CH=4.
- Reset: assert rst mid-simulation -> servo_pwm=0000, buzzer=1, cmd_valid=cmd_err=0 immediately. After release, every channel's pulse is 100 cycles per 2000-cycle frame.
- Position change: send 0x2F -> one cmd_valid pulse, then buzzer=0 for exactly 1000 cycles. From the next frame, servo_pwm[2] is high for 1500 cycles and other channels are unchanged.
- Truncating width and repeat command: send 0x17 -> servo_pwm[1] width is 100+7·1400/15 = 753 cycles. Resend 0x17 -> cmd_valid fires with no buzzer activity.
- Bad channel: send 0x53 -> cmd_err pulse, no buzzer activity, all widths unchanged.
- Framing error: send 0x21 with stop bit 0 -> cmd_err pulse, no update. A glitch of 3 cycles low on rx_pin produces no pulse at all.
- Retrigger and mid-frame update: send 0x01, then 0x02 after 500 cycles -> buzzer stays low until 1000 cycles after the second cmd_valid. The width change on channel 0 appears only at a frame wrap.
- With UART_SERVO_PARITY_EN: 0x03 with correct parity is accepted; 0x03 with wrong parity gives cmd_err.
